matrix_col_gather: RTL and testbench
====================================

// Module: matrix_col_gather
// PURPOSE
//  Inverse of the row->column matrix splitter on the PE input side. Gathers N column
//  vectors, one per valid/ready beat, from the PE output side into an N x N tile.
//  It then presents the tile as one packed row-major matrix bus. It sits between the
//  PE column outputs and the next layer's matrix input, so the result layout matches
//  the layout the splitter consumes.
// PARAMETERS
//  N     16  rows/columns per tile
//  DW    16  signed element width, bits
// PORTS
//  clk        in   1        clock; all logic on posedge
//  rst        in   1        synchronous, active-high reset
//  col_valid  in   1        col_data/col_last valid
//  col_ready  out  1        block can accept a column this cycle
//  col_data   in   N*DW     one column; element k (row k) at [N*DW-1-k*DW -: DW]
//  col_last   in   1        marks final column of tile (expected at column N-1)
//  mat_valid  out  1        mat_data holds a complete tile
//  mat_ready  in   1        downstream accepts tile
//  mat_data   out  N*N*DW   row-major tile; elem(r,c) at [N*N*DW-1-(r*N+c)*DW -: DW]
//  finish     out  1        1-cycle pulse on the cycle after mat handshake completes
//  err        out  1        1-cycle pulse: col_last position mismatch (see below)
// BEHAVIOUR
//  - Reset: state=FILL, col_cnt=0, tile buffer all 0. col_ready=1 (comb from state),
//    mat_valid=0, finish=0, err=0, mat_data=0.
//  - States: FILL (accepting columns), HOLD (tile complete, waiting for mat_ready).
//  - col_ready = (state==FILL). A column is accepted when col_valid & col_ready.
//  - Column write on accept: for k in 0..N-1, elem(k, col_cnt) <= col_data elem k.
//    The transpose is a pure bit-remap, with no arithmetic and no sign change.
//  - col_cnt is clog2(N) bits and increments on each accept.
//  - FILL->HOLD on the accept where col_cnt==N-1 or col_last=1. col_cnt returns to 0.
//  - mat_valid = (state==HOLD). mat_data = tile buffer, registered, stable in HOLD.
//  - Latency: mat_valid rises the cycle after the final column is accepted.
//  - HOLD->FILL when mat_valid & mat_ready. On that edge the buffer clears to 0,
//    finish=1 for exactly one cycle, and col_ready=1 again.
//  - Minimum period is N+1 cycles per tile. col_ready is never 1 while mat_valid=1,
//    so column-accept and tile-accept never occur in the same cycle.
//  - Early col_last (col_cnt<N-1): the tile closes immediately and the unwritten
//    columns remain 0 from the prior clear. err pulses 1 cycle (edge of that accept).
//  - Missing col_last (col_cnt==N-1, col_last=0): the tile still closes and err pulses.
//  - col_valid while col_ready=0 is ignored. The upstream holds data per protocol.
//  - mat_ready while mat_valid=0 has no effect.
//  - Reset mid-tile or in HOLD: the partial or held tile is discarded, all state
//    returns to reset values, and finish/err are not pulsed.
// STRUCTURE
//  - Shared package (pe_pkg): N, DW, the state enum {FILL, HOLD}, and an
//    ELEM_OFS(r,c) localparam/function for the row-major bit offset. The splitter
//    also uses ELEM_OFS, so both ends agree on layout.
//  - One sub-module: matrix_tile_buf. It holds the N*N*DW storage with inputs wr_en,
//    wr_col, wr_data and clr, plus the packed output. It is separate so the splitter
//    bench can reuse it.
//  - The FSM, counter and handshake stay in this module.
// TESTING
//  - Reset then 16 columns, col j elem k = 16'(k*16+j), col_last on j=15, mat_ready=1
//    -> mat_valid cycle after 16th accept; elem(r,c)=r*16+c; finish pulse; err=0.
//  - Round trip: random 4096-bit tile -> splitter -> columns 0..15 fed here -> mat_data
//    bit-identical to original; negative values (16'h8000, 16'hFFFF) preserved.
//  - Backpressure: mat_ready=0 for 10 cycles in HOLD with col_valid=1 -> col_ready=0;
//    mat_data stable; no column consumed; tile accepted when mat_ready=1.
//  - Early last: col_last on column 4 -> HOLD after 5 accepts; cols 5..15 all 0;
//    err one-cycle pulse.
//  - Missing last: 16 columns, col_last=0 throughout -> tile closes; err pulse; next
//    tile starts clean at col 0.
//  - Reset asserted after 7 columns -> mat_valid=0, no finish; next 16 columns
//    produce a correct tile with no residue from the aborted tile.

Source files
------------

// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_pkg
//  Description : Shared PE-array definitions: tile geometry, gather FSM
//                states and the row-major element bit-offset helper used by
//                both the column gatherer and the row->column splitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

  localparam int N  = 16;          // rows/columns per tile
  localparam int DW = 16;          // signed element width
  localparam int CW = $clog2(N);   // column counter width

  typedef enum logic [0:0] {
    FILL = 1'b0,                   // accepting columns
    HOLD = 1'b1                    // tile complete, waiting for downstream
  } state_t;

  // MSB bit index of elem(r,c) inside the packed row-major tile bus.
  function automatic int ELEM_OFS(input int r, input int c);
    return N*N*DW - 1 - (r*N + c)*DW;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_tile_buf.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_tile_buf
//  Description : N x N x DW tile storage. Writes one column per wr_en beat
//                (element k lands in row k of column wr_col) and exposes the
//                whole tile as a registered row-major packed bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_tile_buf
  import pe_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_col,
  input  logic [N*DW-1:0]     wr_data,
  output logic [N*N*DW-1:0]   tile_data
);

  logic [N*N*DW-1:0] r_tile;

  // Clear the tile or scatter one column into it; pure bit remap, no arithmetic.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_tile <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < N; k++) begin
        r_tile[ELEM_OFS(k, int'(wr_col)) -: DW] <= wr_data[N*DW-1-k*DW -: DW];
      end
    end
  end

  assign tile_data = r_tile;

endmodule
`default_nettype wire

// File: rtl/matrix_col_gather.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_col_gather
//  Description : Gathers N column vectors (one per valid/ready beat) into an
//                N x N tile and presents it as a packed row-major matrix bus.
//                Flags a misplaced/missing col_last with a one-cycle err pulse
//                and pulses finish after each completed tile handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_col_gather
  import pe_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                col_valid,
  output logic                col_ready,
  input  logic [N*DW-1:0]     col_data,
  input  logic                col_last,
  output logic                mat_valid,
  input  logic                mat_ready,
  output logic [N*N*DW-1:0]   mat_data,
  output logic                finish,
  output logic                err
);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_col_cnt;
  logic            r_finish;
  logic            r_err;

  logic            w_accept;     // column handshake this cycle
  logic            w_last_pos;   // counter sits on the final column slot
  logic            w_close;      // this accept completes the tile
  logic            w_tile_acc;   // tile handshake this cycle

  // Handshakes derive from the state register directly, keeping them free of
  // any dependency on the comb output process.
  assign w_accept   = col_valid && (r_state == FILL);
  assign w_last_pos = (r_col_cnt == CW'(N-1));
  assign w_close    = w_accept && (w_last_pos || col_last);
  assign w_tile_acc = mat_ready && (r_state == HOLD);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    col_ready = 1'b0;
    mat_valid = 1'b0;
    case (r_state)
      FILL: begin
        col_ready = 1'b1;
        if (w_close) w_next = HOLD;
      end
      HOLD: begin
        mat_valid = 1'b1;
        if (w_tile_acc) w_next = FILL;
      end
      default: w_next = FILL;
    endcase
  end

  // Column counter: advances per accept, returns to 0 whenever a tile closes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_cnt <= '0;
    end else if (w_accept) begin
      r_col_cnt <= w_close ? '0 : r_col_cnt + 1'b1;
    end
  end

  // One-cycle status pulses; err fires when col_last and the N-1 slot disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_finish <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_finish <= w_tile_acc;
      r_err    <= w_accept && (w_last_pos ^ col_last);
    end
  end

  assign finish = r_finish;
  assign err    = r_err;

  matrix_tile_buf u_tile_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_tile_acc),
    .wr_en     (w_accept),
    .wr_col    (r_col_cnt),
    .wr_data   (col_data),
    .tile_data (mat_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_matrix_col_gather.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_col_gather
//  Description : Self-checking bench for matrix_col_gather. Columns come from
//                a column array; the expected tile is rebuilt from the
//                row-major layout rule elem(r,c) = column c, element r.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_col_gather;
  import pe_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                col_valid;
  logic                col_ready;
  logic [N*DW-1:0]     col_data;
  logic                col_last;
  logic                mat_valid;
  logic                mat_ready;
  logic [N*N*DW-1:0]   mat_data;
  logic                finish;
  logic                err;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0]       cols [N][N];   // cols[j][k]: column j, row k
  logic [N*N*DW-1:0]   exp_bus;
  logic [N*N*DW-1:0]   snap;

  matrix_col_gather dut (
    .clk       (clk),
    .rst       (rst),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .col_data  (col_data),
    .col_last  (col_last),
    .mat_valid (mat_valid),
    .mat_ready (mat_ready),
    .mat_data  (mat_data),
    .finish    (finish),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] elem_of(input logic [N*N*DW-1:0] bus, input int i);
    return bus[N*N*DW-1-i*DW -: DW];
  endfunction

  function automatic int first_diff(input logic [N*N*DW-1:0] a, input logic [N*N*DW-1:0] b);
    for (int i = 0; i < N*N; i++)
      if (elem_of(a, i) !== elem_of(b, i)) return i;
    return 0;
  endfunction

  // Expected tile: the first ncols columns from the column array, the rest zero.
  task automatic build_expected(input int ncols);
    exp_bus = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < ncols; c++)
        exp_bus[N*N*DW-1-(r*N+c)*DW -: DW] = cols[c][r];
  endtask

  task automatic rand_cols();
    for (int j = 0; j < N; j++)
      for (int k = 0; k < N; k++)
        cols[j][k] = DW'($urandom);
  endtask

  // Drive column j, waiting a bounded time for col_ready.
  task automatic send_col(input int j, input bit last);
    col_valid = 1'b1;
    col_last  = last;
    for (int k = 0; k < N; k++) col_data[N*DW-1-k*DW -: DW] = cols[j][k];
    for (int i = 0; i < 50 && !col_ready; i++) tick();
    tests++;
    if (col_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_col_timeout col %0d col_ready=%b required 1", j, col_ready);
    end
    tick();
    col_valid = 1'b0;
    col_last  = 1'b0;
  endtask

  task automatic accept_tile();
    mat_ready = 1'b1;
    tick();
    mat_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; col_valid = 1'b0; col_last = 1'b0; col_data = '0; mat_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tests++;
    if (col_ready !== 1'b1 || mat_valid !== 1'b0 || finish !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl got ready=%b valid=%b finish=%b err=%b required 1 0 0 0",
               col_ready, mat_valid, finish, err);
    end
    tests++;
    if (mat_data !== '0) begin
      fails++;
      $display("FAIL reset_data elem %0d got %h required 0000",
               first_diff(mat_data, '0), elem_of(mat_data, first_diff(mat_data, '0)));
    end
  endtask

  task automatic test_basic();
    for (int j = 0; j < N; j++)
      for (int k = 0; k < N; k++)
        cols[j][k] = DW'(k*16 + j);
    exp_bus = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        exp_bus[N*N*DW-1-(r*N+c)*DW -: DW] = DW'(r*16 + c);
    for (int j = 0; j < N; j++) begin
      send_col(j, j == N-1);
      if (j == N-2) begin
        tests++;
        if (mat_valid !== 1'b0) begin
          fails++;
          $display("FAIL basic_early_valid got %b required 0", mat_valid);
        end
      end
    end
    tests++;
    if (mat_valid !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL basic_close got valid=%b err=%b required 1 0", mat_valid, err);
    end
    tests++;
    if (mat_data !== exp_bus) begin
      fails++;
      $display("FAIL basic_tile elem %0d got %h required %h", first_diff(mat_data, exp_bus),
               elem_of(mat_data, first_diff(mat_data, exp_bus)), elem_of(exp_bus, first_diff(mat_data, exp_bus)));
    end
    accept_tile();
    tests++;
    if (finish !== 1'b1 || mat_valid !== 1'b0 || col_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_finish got finish=%b valid=%b ready=%b required 1 0 1", finish, mat_valid, col_ready);
    end
    tick();
    tests++;
    if (finish !== 1'b0) begin
      fails++;
      $display("FAIL basic_finish_width got %b required 0", finish);
    end
  endtask

  task automatic test_roundtrip();
    logic [N*N*DW-1:0] orig;
    for (int it = 0; it < 3; it++) begin
      for (int w = 0; w < N*N*DW/32; w++) orig[w*32 +: 32] = $urandom;
      orig[N*N*DW-1 -: DW]                    = 16'h8000;
      orig[DW-1:0]                            = 16'hFFFF;
      orig[N*N*DW-1-(7*N+3)*DW -: DW]         = 16'h8000;
      orig[N*N*DW-1-(2*N+11)*DW -: DW]        = 16'hFFFF;
      for (int j = 0; j < N; j++)
        for (int k = 0; k < N; k++)
          cols[j][k] = orig[N*N*DW-1-(k*N+j)*DW -: DW];
      for (int j = 0; j < N; j++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_col(j, j == N-1);
      end
      tests++;
      if (mat_data !== orig) begin
        fails++;
        $display("FAIL roundtrip_%0d elem %0d got %h required %h", it, first_diff(mat_data, orig),
                 elem_of(mat_data, first_diff(mat_data, orig)), elem_of(orig, first_diff(mat_data, orig)));
      end
      repeat ($urandom_range(0, 3)) tick();
      accept_tile();
      tests++;
      if (finish !== 1'b1) begin
        fails++;
        $display("FAIL roundtrip_finish_%0d got %b required 1", it, finish);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok = 1'b1;
    rand_cols();
    build_expected(N);
    for (int j = 0; j < N; j++) send_col(j, j == N-1);
    snap = mat_data;
    col_valid = 1'b1;
    col_data  = {N{16'hDEAD}};
    for (int i = 0; i < 10; i++) begin
      tick();
      if (col_ready !== 1'b0 || mat_valid !== 1'b1 || mat_data !== snap) ok = 1'b0;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL backpressure_hold got ready=%b valid=%b required 0 1 with stable data", col_ready, mat_valid);
    end
    tests++;
    if (mat_data !== exp_bus) begin
      fails++;
      $display("FAIL backpressure_tile elem %0d got %h required %h", first_diff(mat_data, exp_bus),
               elem_of(mat_data, first_diff(mat_data, exp_bus)), elem_of(exp_bus, first_diff(mat_data, exp_bus)));
    end
    col_valid = 1'b0;
    accept_tile();
    tests++;
    if (finish !== 1'b1 || mat_data !== '0) begin
      fails++;
      $display("FAIL backpressure_release got finish=%b data_nonzero=%b required 1 0", finish, |mat_data);
    end
  endtask

  task automatic test_early_last();
    rand_cols();
    build_expected(5);
    for (int j = 0; j < 5; j++) send_col(j, j == 4);
    tests++;
    if (mat_valid !== 1'b1 || err !== 1'b1) begin
      fails++;
      $display("FAIL early_close got valid=%b err=%b required 1 1", mat_valid, err);
    end
    tests++;
    if (mat_data !== exp_bus) begin
      fails++;
      $display("FAIL early_tile elem %0d got %h required %h", first_diff(mat_data, exp_bus),
               elem_of(mat_data, first_diff(mat_data, exp_bus)), elem_of(exp_bus, first_diff(mat_data, exp_bus)));
    end
    tick();
    tests++;
    if (err !== 1'b0 || mat_valid !== 1'b1) begin
      fails++;
      $display("FAIL early_err_width got err=%b valid=%b required 0 1", err, mat_valid);
    end
    accept_tile();
  endtask

  task automatic test_missing_last();
    rand_cols();
    build_expected(N);
    for (int j = 0; j < N; j++) send_col(j, 1'b0);
    tests++;
    if (mat_valid !== 1'b1 || err !== 1'b1 || mat_data !== exp_bus) begin
      fails++;
      $display("FAIL missing_close got valid=%b err=%b data_ok=%b required 1 1 1", mat_valid, err, mat_data === exp_bus);
    end
    accept_tile();
    rand_cols();
    build_expected(N);
    for (int j = 0; j < N; j++) send_col(j, j == N-1);
    tests++;
    if (mat_valid !== 1'b1 || err !== 1'b0 || mat_data !== exp_bus) begin
      fails++;
      $display("FAIL missing_next got valid=%b err=%b data_ok=%b required 1 0 1", mat_valid, err, mat_data === exp_bus);
    end
    accept_tile();
  endtask

  task automatic test_reset_mid();
    rand_cols();
    for (int j = 0; j < 7; j++) send_col(j, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (mat_valid !== 1'b0 || finish !== 1'b0 || err !== 1'b0 || col_ready !== 1'b1 || mat_data !== '0) begin
      fails++;
      $display("FAIL reset_mid got valid=%b finish=%b err=%b ready=%b data_nonzero=%b required 0 0 0 1 0",
               mat_valid, finish, err, col_ready, |mat_data);
    end
    rand_cols();
    build_expected(N);
    for (int j = 0; j < N; j++) send_col(j, j == N-1);
    tests++;
    if (mat_valid !== 1'b1 || err !== 1'b0 || mat_data !== exp_bus) begin
      fails++;
      $display("FAIL reset_mid_next elem %0d got %h required %h valid=%b err=%b", first_diff(mat_data, exp_bus),
               elem_of(mat_data, first_diff(mat_data, exp_bus)), elem_of(exp_bus, first_diff(mat_data, exp_bus)),
               mat_valid, err);
    end
    accept_tile();
    tests++;
    if (finish !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_finish got %b required 1", finish);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_roundtrip();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
